// File: rtl/seg_seq_pkg.sv
// Shared constants, state encoding and cycle-index helpers for the
// seven-segment digit-cycle receiver.
package seg_seq_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam int unsigned CYCLE_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LOCKED,
        ST_ERROR
    } state_t;

    typedef logic [2:0] cidx_t;

    // Returns {is_cycle, index}; the cycle runs 3,7,2,4,6
    function automatic logic [3:0] cycle_map(input logic [3:0] d);
        case (d)
            4'd3:    return {1'b1, 3'd0};
            4'd7:    return {1'b1, 3'd1};
            4'd2:    return {1'b1, 3'd2};
            4'd4:    return {1'b1, 3'd3};
            4'd6:    return {1'b1, 3'd4};
            default: return {1'b0, 3'd0};
        endcase
    endfunction

    function automatic cidx_t cycle_fwd(input cidx_t i);
        return (i == cidx_t'(CYCLE_LEN - 1)) ? '0 : i + 3'd1;
    endfunction

    function automatic cidx_t cycle_rev(input cidx_t i);
        return (i == '0) ? cidx_t'(CYCLE_LEN - 1) : i - 3'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment decoder producing the BCD digit
// and its position in the digit cycle.
module seg7_decode
    import seg_seq_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_ok,
    output logic       is_cycle,
    output cidx_t      cycle_idx
);

    always_comb begin
        digit_ok = 1'b1;
        case (seg_in)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: begin
                digit    = 4'hF;
                digit_ok = 1'b0;
            end
        endcase
    end

    // 4'hF is not a cycle digit, so undecodable codes fall out as non-cycle
    assign {is_cycle, cycle_idx} = cycle_map(digit);

endmodule

// File: rtl/seg_seq_decoder.sv
// Samples seven-segment codes, decodes them and tracks lock/direction on the
// 3-7-2-4-6 digit cycle with step and error counters.
module seg_seq_decoder
    import seg_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seg_valid,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_ok,
    output logic             locked,
    output logic             dir,
    output logic             err,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] err_count
);

    logic [3:0] dec_digit;
    logic       dec_ok;
    logic       dec_cycle;
    cidx_t      dec_idx;

    state_t     state;
    cidx_t      idx;

    seg7_decode u_decode (
        .seg_in    (seg_in),
        .digit     (dec_digit),
        .digit_ok  (dec_ok),
        .is_cycle  (dec_cycle),
        .cycle_idx (dec_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            digit      <= '0;
            digit_ok   <= 1'b0;
            locked     <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            step_count <= '0;
            err_count  <= '0;
        end else if (seg_valid) begin
            digit    <= dec_digit;
            digit_ok <= dec_ok;
            if (!dec_cycle) begin
                if (state != ST_ERROR && err_count != '1)
                    err_count <= err_count + 1'b1;
                state  <= ST_ERROR;
                locked <= 1'b0;
                err    <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE, ST_ERROR: begin
                        state  <= ST_HUNT;
                        idx    <= dec_idx;
                        locked <= 1'b0;
                        err    <= 1'b0;
                    end
                    ST_HUNT, ST_LOCKED: begin
                        // A repeated digit is ignored entirely
                        if (dec_idx != idx) begin
                            if (dec_idx == cycle_fwd(idx) || dec_idx == cycle_rev(idx)) begin
                                state      <= ST_LOCKED;
                                idx        <= dec_idx;
                                locked     <= 1'b1;
                                err        <= 1'b0;
                                dir        <= (dec_idx == cycle_fwd(idx));
                                step_count <= step_count + 1'b1;
                            end else begin
                                state  <= ST_ERROR;
                                locked <= 1'b0;
                                err    <= 1'b1;
                                if (err_count != '1)
                                    err_count <= err_count + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_seq_decoder.sv
// Directed table-driven bench for seg_seq_decoder, plus hand sequences for
// idle hold, asynchronous reset and narrow-counter wrap/saturation.
module tb_seg_seq_decoder;
    import seg_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       seg_valid = 1'b0;
    logic [6:0] seg_in = 7'h7F;

    logic [3:0] digit, digit3;
    logic       digit_ok, locked, dir, err;
    logic       digit_ok3, locked3, dir3, err3;
    logic [7:0] step_count, err_count;
    logic [2:0] step_count3, err_count3;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic       rst;
        logic [6:0] seg;
        logic [3:0] digit;
        logic       ok;
        logic       locked;
        logic       dir;
        logic       err;
        logic [7:0] step;
        logic [7:0] errc;
    } vec_t;

    vec_t vecs[$];

    seg_seq_decoder #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .seg_valid(seg_valid), .seg_in(seg_in),
        .digit(digit), .digit_ok(digit_ok), .locked(locked), .dir(dir), .err(err),
        .step_count(step_count), .err_count(err_count)
    );

    seg_seq_decoder #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .seg_valid(seg_valid), .seg_in(seg_in),
        .digit(digit3), .digit_ok(digit_ok3), .locked(locked3), .dir(dir3), .err(err3),
        .step_count(step_count3), .err_count(err_count3)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pk8();
        return {digit, digit_ok, locked, dir, err, step_count, err_count};
    endfunction

    function automatic logic [23:0] pk3();
        return {digit3, digit_ok3, locked3, dir3, err3, 5'd0, step_count3, 5'd0, err_count3};
    endfunction

    // packed as {digit, ok, locked, dir, err, step, errc}
    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (digit,ok/lk/dir/err,step,errc)", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic apply(input logic [6:0] s);
        @(negedge clk);
        seg_valid = 1'b1;
        seg_in    = s;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    function automatic logic [23:0] ex(input logic [3:0] d, input logic ok, input logic lk,
                                       input logic dr, input logic er,
                                       input logic [7:0] st, input logic [7:0] ec);
        return {d, ok, lk, dr, er, st, ec};
    endfunction

    initial begin
        logic [6:0] fwd_seq [10];
        fwd_seq = '{SEG_3, SEG_7, SEG_2, SEG_4, SEG_6, SEG_3, SEG_7, SEG_2, SEG_4, SEG_6};

        // {rst, seg, digit, ok, locked, dir, err, step, errc}
        vecs.push_back(vec_t'{1'b1, SEG_3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_2, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_4, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_6, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5, 8'd0});
        // reverse lock then reversal
        vecs.push_back(vec_t'{1'b1, SEG_3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_6, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_4, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_4, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 8'd0});
        // skip error and resync
        vecs.push_back(vec_t'{1'b1, SEG_3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_4, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1});
        vecs.push_back(vec_t'{1'b0, SEG_2, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1});
        vecs.push_back(vec_t'{1'b0, SEG_4, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd1});
        // non-cycle codes while locked / in error
        vecs.push_back(vec_t'{1'b0, 7'h7F, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, 7'h7F, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_5, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_8, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_9, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_6, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2});
        vecs.push_back(vec_t'{1'b0, SEG_3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd2});
        // repeats ignored while locked
        vecs.push_back(vec_t'{1'b1, SEG_3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_2, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0});
        // bad second digit from HUNT
        vecs.push_back(vec_t'{1'b1, SEG_3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        vecs.push_back(vec_t'{1'b0, SEG_2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1});
        // non-cycle straight from IDLE
        vecs.push_back(vec_t'{1'b1, SEG_8, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1});
        vecs.push_back(vec_t'{1'b0, 7'h55, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1});

        #1;
        chk("reset_state", pk8(), '0);
        chk("reset_state_w3", pk3(), '0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].seg);
            chk($sformatf("vec%0d", i), pk8(),
                ex(vecs[i].digit, vecs[i].ok, vecs[i].locked, vecs[i].dir, vecs[i].err,
                   vecs[i].step, vecs[i].errc));
        end

        // repeats in HUNT, then valid held low with an error code on the bus
        do_reset();
        for (int i = 0; i < 3; i++) apply(SEG_7);
        chk("hunt_repeat", pk8(), ex(4'd7, 1, 0, 0, 0, 8'd0, 8'd0));
        @(negedge clk);
        seg_in = SEG_8;
        repeat (10) @(negedge clk);
        chk("valid_low_hold", pk8(), ex(4'd7, 1, 0, 0, 0, 8'd0, 8'd0));
        apply(SEG_2);
        chk("hunt_idx_kept", pk8(), ex(4'd2, 1, 1, 1, 0, 8'd1, 8'd0));

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", pk8(), '0);
        chk("async_reset_w3", pk3(), '0);
        @(negedge clk);
        reset = 1'b1;
        apply(SEG_2);
        chk("post_reset_idle", pk8(), ex(4'd2, 1, 0, 0, 0, 8'd0, 8'd0));
        apply(SEG_4);
        chk("post_reset_lock", pk8(), ex(4'd4, 1, 1, 1, 0, 8'd1, 8'd0));

        // 9 forward steps: wraps in the 3-bit counter
        do_reset();
        for (int i = 0; i < 10; i++) apply(fwd_seq[i]);
        chk("steps9_w8", pk8(), ex(4'd6, 1, 1, 1, 0, 8'd9, 8'd0));
        chk("steps9_w3", pk3(), {4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0});

        // 8 error entries, each followed by a resync
        for (int i = 0; i < 8; i++) begin
            apply(SEG_8);
            apply(SEG_3);
        end
        chk("err8_w8", pk8(), ex(4'd3, 1, 0, 1, 0, 8'd9, 8'd8));
        chk("err8_w3", pk3(), {4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd7});
        apply(SEG_8);
        chk("err9_w8", pk8(), ex(4'd8, 1, 0, 1, 1, 8'd9, 8'd9));
        chk("err_sat_w3", pk3(), {4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 8'd7});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_seq_decoder.md
# seg_seq_decoder

Receiving end of the digit-cycle display path: samples 7-bit active-low seven-segment codes from a display bus and decodes each code to a BCD digit. Tracks whether the incoming stream follows the five-digit cycle 3→7→2→4→6→3 (forward) or its reverse, and reports lock, direction, step count and errors. Intended to monitor or loop back the HEX0 output of the digit-cycle state machine on the same board-level clock.

## Interface
- CNT_W, 8, width of step_count and err_count
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low clears all state immediately
- seg_valid  in  1  seg_in is sampled on a rising clk edge when high
- seg_in  in  7  active-low segment code, bit order {g,f,e,d,c,b,a}
- digit  out  4  last decoded digit; 4'hF for an undecodable code
- digit_ok  out  1  last sampled code was a legal 0–9 pattern
- locked  out  1  FSM in LOCKED
- dir  out  1  1 = forward (3→7→2→4→6), 0 = reverse; meaningful only while locked
- err  out  1  FSM in ERROR
- step_count  out  CNT_W  accepted cycle steps, wraps modulo 2^CNT_W
- err_count  out  CNT_W  entries into ERROR, saturates at all-ones

## Operation
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code → digit 4'hF, digit_ok 0.
- Cycle index: 3→0, 7→1, 2→2, 4→3, 6→4. Codes 0,1,5,8,9 and undecodable codes are "non-cycle".
- fwd(i) = (i+1) mod 5, rev(i) = (i+4) mod 5. Index register is 3 bits; values 5–7 never occur.
- States: IDLE, HUNT, LOCKED, ERROR. Transitions evaluated only when seg_valid=1; otherwise everything holds.
- Any state, non-cycle code → ERROR (err_count +1 if entering from a non-ERROR state).
- Any state except IDLE/ERROR, code equal to stored index → no change (repeat ignored, no count).
- IDLE, cycle code → HUNT, store index.
- HUNT, fwd(idx) → LOCKED, dir=1, step_count +1; rev(idx) → LOCKED, dir=0, step_count +1; other cycle code → ERROR.
- LOCKED, fwd(idx) → dir=1; rev(idx) → dir=0; both step_count +1 and update index (direction reversal is legal at any step). Other cycle code (skip of two) → ERROR.
- ERROR, cycle code → HUNT with that index (resync); non-cycle code → stay ERROR, no count.
- digit/digit_ok update on every seg_valid sample regardless of state.

## Timing
- All outputs registered; a sample taken at edge N is reflected on outputs after edge N (one-cycle latency).
- Back-to-back seg_valid on consecutive cycles supported; no backpressure.
- Reset values: digit=0, digit_ok=0, locked=0, dir=0, err=0, step_count=0, err_count=0, state IDLE, index 0.
- Reset assertion mid-stream clears outputs asynchronously; first sample after release is treated as from IDLE.
- step_count wraps 2^CNT_W−1 → 0; err_count holds at 2^CNT_W−1.

## Structure
- Package seg_seq_pkg: the ten segment constants, state enum, cycle-index mapping function, cycle length constant 5.
- Sub-module seg7_decode: combinational seg_in → {digit, digit_ok, is_cycle, cycle_idx}; top holds FSM, index register and counters.

## Test plan
- Reset, feed 3,7,2,4,6,3 → locked=1 after 2nd sample, dir=1, step_count=5, err=0, digit=3.
- Feed 3,6,4,2 → dir=0, locked, step_count=3; then 4 → dir=1, step_count=4.
- Feed 3,7,4 → err=1, locked=0, err_count=1; then 2,4 → HUNT then LOCKED dir=1, step_count=2.
- Feed 7'b1111111 while locked → digit=4'hF, digit_ok=0, err=1; again → err_count unchanged; feed 0 (1000000) → digit=0, digit_ok=1, still ERROR.
- Repeat 7,7,7 and hold seg_valid=0 for 10 cycles → state HUNT, counts unchanged; assert reset low between edges → all outputs 0 immediately.
- CNT_W=3: 9 forward steps → step_count=1; 8 error entries → err_count=7.
